// File: rtl/bcd_counter_mux7seg_if.sv
// Board-facing signal bundle for the BCD counter / multiplexed 7-segment driver.
// The master side (switches/buttons or a bench) drives controls; the slave side returns count and display.
interface bcd_counter_mux7seg_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    upDown;
   logic                    load;
   logic [4*NUM_DIGITS-1:0] loadValue;
   logic [4*NUM_DIGITS-1:0] count;
   logic                    tc;
   logic [6:0]              seg7;
   logic [NUM_DIGITS-1:0]   anode;

   modport master (
      output enable, upDown, load, loadValue,
      input  count, tc, seg7, anode
   );

   modport slave (
      input  enable, upDown, load, loadValue,
      output count, tc, seg7, anode
   );
endinterface

// File: rtl/bcd_counter_mux7seg.sv
// N-digit BCD up/down counter with load, wrap/saturate, a terminal-count pulse, and a
// time-multiplexed common-anode 7-segment driver, all on a single clock with tick enables.
module bcd_counter_mux7seg #(
   parameter int NUM_DIGITS = 4,
   parameter int DIV_COUNT  = 50_000_000,
   parameter int SCAN_DIV   = 50_000,
   parameter int WRAP       = 1
) (
   input logic                 clk,
   input logic                 rst,
   bcd_counter_mux7seg_if.slave bus
);
   localparam int W      = 4 * NUM_DIGITS;
   localparam int DIV_W  = $clog2(DIV_COUNT);
   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

   logic [W-1:0]          countReg;
   logic                  tcReg;
   logic [DIV_W-1:0]      divCnt;
   logic [SCAN_W-1:0]     scanCnt;
   logic [IDX_W-1:0]      digIdx;
   logic [NUM_DIGITS-1:0] anodeReg;
   logic [6:0]            seg7Reg;
   logic                  tick;
   logic                  scanWrap;
   logic [3:0]            curDigit;

   // Digit-wise ripple increment; a digit only changes when every lower digit was 9.
   function automatic logic [W-1:0] bcdInc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcdDec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
      end
      return r;
   endfunction

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   always_comb begin
      tick     = (divCnt == DIV_W'(DIV_COUNT - 1));
      scanWrap = (scanCnt == SCAN_W'(SCAN_DIV - 1));
      curDigit = countReg[4*int'(digIdx) +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst || tick) divCnt <= '0;
      else             divCnt <= divCnt + DIV_W'(1);
   end

   // Terminal values saturate or wrap, but tc pulses on the terminal tick either way.
   always_ff @(posedge clk) begin
      if (rst) begin
         countReg <= '0;
         tcReg    <= 1'b0;
      end else if (bus.load) begin
         countReg <= sanitize(bus.loadValue);
         tcReg    <= 1'b0;
      end else if (tick && bus.enable) begin
         if (bus.upDown) begin
            tcReg    <= (countReg == ALL_NINES);
            countReg <= (countReg == ALL_NINES && WRAP == 0) ? countReg : bcdInc(countReg);
         end else begin
            tcReg    <= (countReg == '0);
            countReg <= (countReg == '0 && WRAP == 0) ? countReg : bcdDec(countReg);
         end
      end else begin
         tcReg <= 1'b0;
      end
   end

   // Anode and segments are registered on the same edge so a digit never shows the wrong glyph.
   always_ff @(posedge clk) begin
      if (rst) begin
         scanCnt  <= '0;
         digIdx   <= '0;
         anodeReg <= ~NUM_DIGITS'(1);
         seg7Reg  <= 7'b1000000;
      end else begin
         scanCnt <= scanWrap ? '0 : scanCnt + SCAN_W'(1);
         if (scanWrap) begin
            digIdx <= (digIdx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digIdx + IDX_W'(1);
         end
         anodeReg <= ~(NUM_DIGITS'(1) << digIdx);
         seg7Reg  <= decode(curDigit);
      end
   end

   assign bus.count = countReg;
   assign bus.tc    = tcReg;
   assign bus.anode = anodeReg;
   assign bus.seg7  = seg7Reg;
endmodule

// File: tb/tb_bcd_counter_mux7seg.sv
// Scoreboard bench: a decimal-arithmetic model predicts every cycle for a wrapping and a
// saturating instance; a monitor pops predictions and compares them after each edge.
module tb_bcd_counter_mux7seg;
   localparam int ND   = 2;
   localparam int DIV  = 4;
   localparam int SCAN = 2;
   localparam int MAXV = 99;
   localparam logic [6:0] GLYPH [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                         7'b0000000, 7'b0010000};

   typedef struct packed {
      logic [1:0][7:0] count;
      logic [1:0]      tc;
      logic [1:0][1:0] anode;
      logic [1:0][6:0] seg7;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t expQ[$];
   int   mVal [2];
   bit   mTc  [2];
   int   mCyc = 0;

   bcd_counter_mux7seg_if #(.NUM_DIGITS(ND)) bus0 ();
   bcd_counter_mux7seg_if #(.NUM_DIGITS(ND)) bus1 ();

   bcd_counter_mux7seg #(.NUM_DIGITS(ND), .DIV_COUNT(DIV), .SCAN_DIV(SCAN), .WRAP(1)) dutWrap (
      .clk(clk), .rst(rst), .bus(bus0));
   bcd_counter_mux7seg #(.NUM_DIGITS(ND), .DIV_COUNT(DIV), .SCAN_DIV(SCAN), .WRAP(0)) dutSat (
      .clk(clk), .rst(rst), .bus(bus1));

   always #5 clk = ~clk;

   function automatic logic [7:0] toBcd(input int v);
      logic [3:0] hi;
      logic [3:0] lo;
      hi = 4'((v / 10) % 10);
      lo = 4'(v % 10);
      return {hi, lo};
   endfunction

   function automatic int cleanLoad(input logic [7:0] lv);
      int hi;
      int lo;
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > 9) hi = 0;
      if (lo > 9) lo = 0;
      return hi * 10 + lo;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs to both instances and push the predicted post-edge outputs.
   task automatic applyStimulus(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
      exp_t       ex;
      int         idx;
      bit         tick;
      logic [1:0] one;
      @(negedge clk);
      rst = r;
      bus0.enable = e; bus0.upDown = u; bus0.load = l; bus0.loadValue = lv;
      bus1.enable = e; bus1.upDown = u; bus1.load = l; bus1.loadValue = lv;
      one  = 2'b01;
      idx  = (mCyc / SCAN) % ND;
      tick = ((mCyc % DIV) == DIV - 1);
      for (int w = 0; w < 2; w++) begin
         if (r) begin
            mVal[w] = 0;
            mTc[w]  = 1'b0;
            ex.anode[w] = 2'b10;
            ex.seg7[w]  = GLYPH[0];
         end else begin
            ex.anode[w] = ~(one << idx);
            ex.seg7[w]  = GLYPH[(idx == 0) ? (mVal[w] % 10) : ((mVal[w] / 10) % 10)];
            mTc[w] = 1'b0;
            if (l) begin
               mVal[w] = cleanLoad(lv);
            end else if (tick && e) begin
               if (u) begin
                  if (mVal[w] == MAXV) begin
                     mTc[w] = 1'b1;
                     if (w == 0) mVal[w] = 0;
                  end else begin
                     mVal[w] = mVal[w] + 1;
                  end
               end else begin
                  if (mVal[w] == 0) begin
                     mTc[w] = 1'b1;
                     if (w == 0) mVal[w] = MAXV;
                  end else begin
                     mVal[w] = mVal[w] - 1;
                  end
               end
            end
         end
         ex.count[w] = toBcd(mVal[w]);
         ex.tc[w]    = mTc[w];
      end
      mCyc = r ? 0 : mCyc + 1;
      expQ.push_back(ex);
      @(posedge clk);
   endtask

   // Monitor: every edge delivers one new output set, compared against the oldest prediction.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            ex = expQ.pop_front();
            checkOutput("count_wrap", 32'(bus0.count), 32'(ex.count[0]));
            checkOutput("tc_wrap",    32'(bus0.tc),    32'(ex.tc[0]));
            checkOutput("anode_wrap", 32'(bus0.anode), 32'(ex.anode[0]));
            checkOutput("seg7_wrap",  32'(bus0.seg7),  32'(ex.seg7[0]));
            checkOutput("count_sat",  32'(bus1.count), 32'(ex.count[1]));
            checkOutput("tc_sat",     32'(bus1.tc),    32'(ex.tc[1]));
            checkOutput("anode_sat",  32'(bus1.anode), 32'(ex.anode[1]));
            checkOutput("seg7_sat",   32'(bus1.seg7),  32'(ex.seg7[1]));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] lv;
      bus0.enable = 1'b0; bus0.upDown = 1'b0; bus0.load = 1'b0; bus0.loadValue = '0;
      bus1.enable = 1'b0; bus1.upDown = 1'b0; bus1.load = 1'b0; bus1.loadValue = '0;

      applyStimulus(1, 0, 1, 0, 8'h00);
      applyStimulus(1, 0, 1, 0, 8'h00);
      #2;
      checkOutput("reset_count", 32'(bus0.count), 32'h00);
      checkOutput("reset_tc",    32'(bus0.tc),    32'h0);
      checkOutput("reset_anode", 32'(bus0.anode), 32'h2);
      checkOutput("reset_seg7",  32'(bus0.seg7),  32'h40);

      for (int i = 0; i < 12 * DIV; i++) applyStimulus(0, 1, 1, 0, 8'h00);
      #2;
      checkOutput("up12_count", 32'(bus0.count), 32'h12);

      applyStimulus(0, 1, 1, 1, 8'h99);
      for (int i = 0; i < DIV; i++) applyStimulus(0, 1, 1, 0, 8'h00);
      #2;
      checkOutput("wrap_up_count", 32'(bus0.count), 32'h00);
      checkOutput("sat_up_count",  32'(bus1.count), 32'h99);

      applyStimulus(0, 1, 0, 1, 8'h10);
      for (int i = 0; i < DIV; i++) applyStimulus(0, 1, 0, 0, 8'h00);
      #2;
      checkOutput("borrow_count", 32'(bus0.count), 32'h09);
      applyStimulus(0, 1, 0, 1, 8'h00);
      for (int i = 0; i < DIV; i++) applyStimulus(0, 1, 0, 0, 8'h00);
      #2;
      checkOutput("wrap_down_count", 32'(bus0.count), 32'h99);
      checkOutput("sat_down_count",  32'(bus1.count), 32'h00);

      while ((mCyc % DIV) != DIV - 1) applyStimulus(0, 1, 1, 0, 8'h00);
      applyStimulus(0, 1, 1, 1, 8'hA7);
      #2;
      checkOutput("load_prio_count", 32'(bus0.count), 32'h07);
      checkOutput("load_prio_tc",    32'(bus0.tc),    32'h0);

      applyStimulus(0, 0, 1, 1, 8'h37);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1, 0, 8'h00);
      #2;
      checkOutput("hold_count", 32'(bus0.count), 32'h37);
      applyStimulus(1, 1, 1, 1, 8'h55);
      #2;
      checkOutput("midrst_count", 32'(bus0.count), 32'h00);
      checkOutput("midrst_anode", 32'(bus0.anode), 32'h2);
      checkOutput("midrst_seg7",  32'(bus0.seg7),  32'h40);

      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(3))
            0:       lv = 8'h99;
            1:       lv = 8'h00;
            default: lv = 8'($urandom);
         endcase
         applyStimulus($urandom_range(39) == 0, $urandom_range(3) != 0,
                       1'($urandom_range(1)), $urandom_range(7) == 0, lv);
      end

      #3;
      checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
